decode_stage: RTL

//  RV32I instruction decode and operand-fetch stage. Sits between fetch and the ALU.

---
 rtl/rv32i_pkg.sv | 38 +++
 rtl/decode_stage_regfile.sv | 28 ++
 rtl/decode_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// RV32I opcode and funct3 encodings plus the registered decode bundle
// shared by the decode stage.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        is_alu_reg;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] pc;
        logic        illegal;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
    } decode_bundle_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero.
module regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [32];

    // Storage is deliberately not reset; x0 is never written and masked on read.
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : mem[raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode and operand-fetch stage: combinational decode of the incoming
// word, regfile read with writeback bypass, one valid/ready output register.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_is_alu_reg,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'd0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    logic [6:0]     opcode_p0;
    logic [2:0]     funct3_p0;
    logic [6:0]     funct7_p0;
    logic [4:0]     rd_p0;
    logic [4:0]     rs1a_p0;
    logic [4:0]     rs2a_p0;
    logic [31:0]    rf_rd1_p0;
    logic [31:0]    rf_rd2_p0;
    logic           wb_live;
    logic           writes_p0;
    decode_bundle_t dec_p0;
    decode_bundle_t bundle_p1;
    logic           vld_p1;
    logic           accept;

    assign opcode_p0 = in_instr[6:0];
    assign rd_p0     = in_instr[11:7];
    assign funct3_p0 = in_instr[14:12];
    assign rs1a_p0   = in_instr[19:15];
    assign rs2a_p0   = in_instr[24:20];
    assign funct7_p0 = in_instr[31:25];
    assign wb_live   = wb_we && (wb_addr != 5'd0);

    regfile #(.XLEN(XLEN)) u_regfile (
        .clk    (clk),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1a_p0),
        .raddr2 (rs2a_p0),
        .rdata1 (rf_rd1_p0),
        .rdata2 (rf_rd2_p0)
    );

    // ---- stage p0: combinational decode, immediate and operand select ----
    always_comb begin
        dec_p0          = '0;
        writes_p0       = 1'b0;
        dec_p0.funct3   = funct3_p0;
        dec_p0.opcode   = opcode_p0;
        dec_p0.rd       = rd_p0;
        dec_p0.pc       = in_pc;
        dec_p0.rs1_addr = rs1a_p0;
        dec_p0.rs2_addr = rs2a_p0;
        dec_p0.rs1      = (wb_live && (wb_addr == rs1a_p0)) ? wb_data : rf_rd1_p0;
        dec_p0.rs2      = (wb_live && (wb_addr == rs2a_p0)) ? wb_data : rf_rd2_p0;

        case (opcode_p0)
            OP: begin
                dec_p0.is_alu_reg = 1'b1;
                dec_p0.funct7b5   = in_instr[30];
                writes_p0         = 1'b1;
                if (funct7_p0 == F7_ALT) begin
                    dec_p0.illegal = (funct3_p0 != F3_ADD) && (funct3_p0 != F3_SR);
                end else begin
                    dec_p0.illegal = (funct7_p0 != F7_BASE);
                end
            end
            OP_IMM: begin
                dec_p0.imm = imm_i(in_instr);
                writes_p0  = 1'b1;
                // Only the right-shift form carries an arithmetic select in bit 30.
                if (funct3_p0 == F3_SLL) begin
                    dec_p0.illegal = (funct7_p0 != F7_BASE);
                end else if (funct3_p0 == F3_SR) begin
                    dec_p0.funct7b5 = in_instr[30];
                    dec_p0.illegal  = (funct7_p0 != F7_BASE) && (funct7_p0 != F7_ALT);
                end
            end
            LOAD, JALR: begin
                dec_p0.imm = imm_i(in_instr);
                writes_p0  = 1'b1;
            end
            STORE:  dec_p0.imm = imm_s(in_instr);
            BRANCH: dec_p0.imm = imm_b(in_instr);
            LUI, AUIPC: begin
                dec_p0.imm = imm_u(in_instr);
                writes_p0  = 1'b1;
            end
            JAL: begin
                dec_p0.imm = imm_j(in_instr);
                writes_p0  = 1'b1;
            end
            default: dec_p0.illegal = 1'b1;
        endcase

        dec_p0.rd_we = writes_p0 && (rd_p0 != 5'd0) && !dec_p0.illegal;
    end

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // ---- stage p1: output register, held under backpressure ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            bundle_p1    <= '0;
            bundle_p1.pc <= RESET_PC;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            bundle_p1 <= dec_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end else if (vld_p1 && wb_live) begin
            if (wb_addr == bundle_p1.rs1_addr) bundle_p1.rs1 <= wb_data;
            if (wb_addr == bundle_p1.rs2_addr) bundle_p1.rs2 <= wb_data;
        end
    end

    assign out_valid      = vld_p1;
    assign out_rs1        = bundle_p1.rs1;
    assign out_rs2        = bundle_p1.rs2;
    assign out_imm        = bundle_p1.imm;
    assign out_funct3     = bundle_p1.funct3;
    assign out_funct7b5   = bundle_p1.funct7b5;
    assign out_is_alu_reg = bundle_p1.is_alu_reg;
    assign out_opcode     = bundle_p1.opcode;
    assign out_rd         = bundle_p1.rd;
    assign out_rd_we      = bundle_p1.rd_we;
    assign out_pc         = bundle_p1.pc;
    assign out_illegal    = bundle_p1.illegal;

endmodule
